// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: geometry and controller state encoding for ram_ctrl.
// VERIFY exists only when RAM_CTRL_VERIFY_EN is defined.
package ram_ctrl_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W = 2;
  typedef enum logic [2:0] {
    IDLE, WDATA, SETUP, ACCESS, HOLD, RESP, DONE
`ifdef RAM_CTRL_VERIFY_EN
    , VERIFY
`endif
  } state_t;
endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: command, write-data, read-data and RAM-side pins of ram_ctrl.
interface ram_ctrl_if;
  import ram_ctrl_pkg::*;
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic wd_valid, wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic done, err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic ram_en, ram_rw;
  modport slave (
    input req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready, ram_dout,
    output req_ready, wd_ready, rd_valid, rd_data, done, err, ram_addr, ram_din, ram_en, ram_rw
  );
  modport master (
    output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready, ram_dout,
    input req_ready, wd_ready, rd_valid, rd_data, done, err, ram_addr, ram_din, ram_en, ram_rw
  );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: burst controller for a 256x8 combinational-read RAM with setup/access/hold phasing.
// Define RAM_CTRL_VERIFY_EN to read back every written word and flag mismatches on err.
module ram_ctrl
  import ram_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  ram_ctrl_if.slave b
);
  state_t state, nxt;
  logic wr, last, beat_end;
  logic [LEN_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din, rdata;

  assign last = cnt == '0;
  assign b.req_ready = state == IDLE;
  assign b.wd_ready = state == WDATA;
  assign b.rd_valid = state == RESP;
  assign b.done = state == DONE;
  assign b.ram_rw = wr && (state inside {SETUP, ACCESS, HOLD});
  assign b.ram_addr = addr;
  assign b.ram_din = din;
  assign b.rd_data = rdata;

`ifdef RAM_CTRL_VERIFY_EN
  logic err_q;
  assign b.err = err_q;
  assign b.ram_en = state == ACCESS || state == VERIFY;
  assign beat_end = state == VERIFY || (state == RESP && b.rd_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (state == IDLE && b.req_valid) err_q <= 1'b0;
    else if (state == VERIFY && b.ram_dout != din) err_q <= 1'b1;
`else
  assign b.err = 1'b0;
  assign b.ram_en = state == ACCESS;
  assign beat_end = state == HOLD || (state == RESP && b.rd_ready);
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = b.req_valid ? (b.req_write ? WDATA : SETUP) : IDLE;
      WDATA:  nxt = b.wd_valid ? SETUP : WDATA;
      SETUP:  nxt = ACCESS;
      ACCESS: nxt = wr ? HOLD : RESP;
`ifdef RAM_CTRL_VERIFY_EN
      HOLD:   nxt = VERIFY;
      VERIFY: nxt = last ? DONE : WDATA;
`else
      HOLD:   nxt = last ? DONE : WDATA;
`endif
      RESP:   nxt = b.rd_ready ? (last ? DONE : SETUP) : RESP;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // address advances only as a beat retires, when ram_en is already low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr <= 1'b0;
      cnt <= '0;
      addr <= '0;
      din <= '0;
      rdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && b.req_valid) begin
        addr <= b.req_addr;
        cnt <= b.req_len;
        wr <= b.req_write;
      end
      if (state == WDATA && b.wd_valid) din <= b.wd_data;
      if (state == ACCESS && !wr) rdata <= b.ram_dout;
      if (beat_end) begin
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized bench for ram_ctrl against a RAM array and a per-address reference memory.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;
`ifdef RAM_CTRL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam logic [30:0] RST_OUTS = {1'b1, 30'b0};
  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0, done_cnt = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] pa = 8'h00, pd = 8'h00;
  time t_acc, t_done;

  ram_ctrl_if b();
  ram_ctrl dut (.clk(clk), .rst_n(rst_n), .b(b));

  always #5 clk = ~clk;

  function automatic logic [7:0] stored(input logic [7:0] a, input logic [7:0] d);
    return (VER && a == 8'h20) ? (d & 8'hFE) : d;
  endfunction

  function automatic logic [30:0] outs();
    return {b.req_ready, b.wd_ready, b.rd_valid, b.rd_data, b.done, b.err,
            b.ram_en, b.ram_rw, b.ram_addr, b.ram_din};
  endfunction

  assign b.ram_dout = mem[b.ram_addr];
  always @(posedge clk) if (b.ram_en && b.ram_rw) mem[b.ram_addr] <= stored(b.ram_addr, b.ram_din);

  always @(negedge clk) begin
    if (b.done) done_cnt++;
    if (b.ram_en) begin
      checks++;
      if (b.ram_addr !== pa || b.ram_din !== pd) begin
        errors++;
        $display("FAIL ram_stable addr=%h din=%h required addr=%h din=%h", b.ram_addr, b.ram_din, pa, pd);
      end
    end
    pa = b.ram_addr;
    pd = b.ram_din;
  end

  task automatic send_req(input logic w, input logic [7:0] a, input logic [1:0] l);
    int t = 0;
    b.req_valid = 1'b1; b.req_write = w; b.req_addr = a; b.req_len = l;
    while (!b.req_ready && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (b.req_ready !== 1'b1) begin errors++; $display("FAIL req_accept ready=%b required=1", b.req_ready); end
    @(negedge clk);
    b.req_valid = 1'b0; b.req_write = 1'($urandom); b.req_addr = 8'($urandom); b.req_len = 2'($urandom);
  endtask

  task automatic wait_done(input int n0, input logic exp_err);
    int t = 0;
    while (!b.done && t < 20) begin @(negedge clk); t++; end
    t_done = $time;
    checks++;
    if (b.done !== 1'b1) begin errors++; $display("FAIL done_seen done=%b required=1", b.done); end
    @(negedge clk);
    checks++;
    if (done_cnt !== n0 + 1) begin errors++; $display("FAIL done_count got=%0d required=%0d", done_cnt, n0 + 1); end
    checks++;
    if (b.err !== exp_err) begin errors++; $display("FAIL err_flag err=%b required=%b", b.err, exp_err); end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [1:0] l, input logic [31:0] d, input int gap);
    int n0 = done_cnt;
    logic e = 1'b0;
    logic [7:0] ad, dv;
    send_req(1'b1, a, l);
    t_acc = $time;
    for (int i = 0; i <= int'(l); i++) begin
      int t = 0;
      ad = a + 8'(i);
      dv = d[8*i +: 8];
      repeat ($urandom_range(gap, 0)) begin b.wd_valid = 1'b0; @(negedge clk); end
      b.wd_valid = 1'b1;
      b.wd_data = dv;
      while (!b.wd_ready && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (b.wd_ready !== 1'b1) begin errors++; $display("FAIL wd_ready beat=%0d got=%b required=1", i, b.wd_ready); end
      @(negedge clk);
      ref_mem[ad] = stored(ad, dv);
      e = e | (VER && ad == 8'h20 && dv[0]);
    end
    b.wd_valid = 1'b0;
    b.wd_data = 8'($urandom);
    wait_done(n0, e);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [1:0] l, input int stall, input bit fixed);
    int n0 = done_cnt;
    logic [7:0] ad, hold;
    send_req(1'b0, a, l);
    t_acc = $time;
    for (int i = 0; i <= int'(l); i++) begin
      int t = 0;
      int k = fixed ? stall : int'($urandom_range(stall, 0));
      ad = a + 8'(i);
      while (!b.rd_valid && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (b.rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid beat=%0d got=%b required=1", i, b.rd_valid); end
      hold = b.rd_data;
      for (int s = 0; s < k; s++) begin
        b.rd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (b.rd_valid !== 1'b1 || b.rd_data !== hold || b.ram_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_stall valid=%b data=%h en=%b required valid=1 data=%h en=0", b.rd_valid, b.rd_data, b.ram_en, hold);
        end
      end
      checks++;
      if (b.rd_data !== ref_mem[ad]) begin errors++; $display("FAIL rd_data addr=%h got=%h required=%h", ad, b.rd_data, ref_mem[ad]); end
      b.rd_ready = 1'b1;
      @(negedge clk);
    end
    b.rd_ready = 1'($urandom);
    wait_done(n0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b.req_valid = 1'b1; b.wd_valid = 1'b1; b.rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL reset_vals got=%h required=%h", outs(), RST_OUTS); end
    b.req_valid = 1'b0; b.wd_valid = 1'b0; b.rd_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", b.req_ready); end
  endtask

  task automatic test_single();
    int n0 = done_cnt;
    do_write(8'h10, 2'd0, 32'hA5, 0);
    do_read(8'h10, 2'd0, 0, 1'b1);
    checks++;
    if (done_cnt !== n0 + 2) begin errors++; $display("FAIL single_done got=%0d required=%0d", done_cnt - n0, 2); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] ad;
    do_write(8'hFE, 2'd3, 32'h04030201, 1);
    for (int i = 0; i < 4; i++) begin
      ad = 8'hFE + 8'(i);
      checks++;
      if (mem[ad] !== exp_v[i]) begin errors++; $display("FAIL wrap_mem addr=%h got=%h required=%h", ad, mem[ad], exp_v[i]); end
    end
    do_read(8'hFE, 2'd3, 0, 1'b1);
  endtask

  task automatic test_stall();
    do_read(8'hFE, 2'd3, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    int wb = VER ? 5 : 4;
    do_write(8'h80, 2'd3, $urandom, 0);
    checks++;
    if (int'((t_done - t_acc) / 10) !== 4 * wb) begin
      errors++; $display("FAIL write_rate cycles=%0d required=%0d", (t_done - t_acc) / 10, 4 * wb);
    end
    do_read(8'h80, 2'd3, 0, 1'b1);
    checks++;
    if (int'((t_done - t_acc) / 10) !== 12) begin
      errors++; $display("FAIL read_rate cycles=%0d required=12", (t_done - t_acc) / 10);
    end
  endtask

  task automatic test_reset_mid();
    int n0 = done_cnt, t = 0, seen = 0;
    send_req(1'b1, 8'h40, 2'd3);
    b.wd_valid = 1'b1;
    b.wd_data = 8'h11;
    while (seen < 2 && t < 40) begin
      if (b.ram_en) seen++;
      if (seen == 1 && b.wd_ready) b.wd_data = 8'h22;
      if (seen < 2) begin @(negedge clk); t++; end
    end
    checks++;
    if (seen !== 2) begin errors++; $display("FAIL mid_access seen=%0d required=2", seen); end
    ref_mem[8'h40] = stored(8'h40, 8'h11);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL mid_reset_vals got=%h required=%h", outs(), RST_OUTS); end
    b.wd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== n0) begin errors++; $display("FAIL mid_no_done got=%0d required=%0d", done_cnt, n0); end
    do_write(8'h41, 2'd0, 32'h5A, 0);
    do_read(8'h40, 2'd1, 2, 1'b0);
  endtask

`ifdef RAM_CTRL_VERIFY_EN
  task automatic test_verify();
    do_write(8'h20, 2'd0, 32'h21, 0);
    do_read(8'h20, 2'd0, 1, 1'b1);
    do_write(8'h20, 2'd0, 32'h40, 0);
  endtask
`endif

  task automatic test_random();
    logic [7:0] a;
    logic [1:0] l;
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom);
      l = 2'($urandom);
      do_write(a, l, $urandom, 2);
      do_read(a, l, 3, 1'b0);
    end
  endtask

  initial begin
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = 8'h00; b.req_len = 2'd0;
    b.wd_valid = 1'b0; b.wd_data = 8'h00; b.rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef RAM_CTRL_VERIFY_EN
    test_verify();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter: none; geometry fixed at 256 x 8 (8-bit address, 8-bit data).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  command handshake; accepted when both high on a rising edge.
REQ-005 req_write  input  1  1 = write burst, 0 = read burst.
REQ-006 req_addr  input  8  first beat address.
REQ-007 req_len  input  2  beats minus one (1..4 beats).
REQ-008 wd_valid / wd_ready / wd_data  in / out / in  1 / 1 / 8  write-data stream, one word per write beat.
REQ-009 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / 8  read-data stream, one word per read beat.
REQ-010 done  output  1  one-cycle pulse after the last beat completes.
REQ-011 err  output  1  sticky write-verify mismatch flag.
REQ-012 ram_addr / ram_din / ram_en / ram_rw  output  8 / 8 / 1 / 1  RAM-side pins; ram_rw 1 = write, 0 = read.
REQ-013 ram_dout  input  8  combinational RAM read data.

Function
REQ-014 States: IDLE, WDATA, SETUP, ACCESS, HOLD, VERIFY (macro only), RESP, DONE.
REQ-015 req_ready SHALL be high only in IDLE; acceptance latches addr, len, write and clears err.
REQ-016 Write beat: WDATA (wd_ready=1) until wd_valid; word captured into ram_din -> SETUP (en=0, rw=1) -> ACCESS (en=1, rw=1) -> HOLD (en=0, addr/din unchanged); 3 cycles after wd acceptance.
REQ-017 Read beat: SETUP (en=0, rw=0) -> ACCESS (en=1, rw=0), ram_dout registered into rd_data at end of ACCESS -> RESP with rd_valid=1 held until rd_ready; rd_data stable while rd_valid high.
REQ-018 ram_en SHALL be high only in ACCESS and VERIFY; ram_addr/ram_din change only while ram_en is low.
REQ-019 After each beat, address increments modulo 256 (0xFF -> 0x00); beat counter decrements; last beat -> DONE (done=1 one cycle) -> IDLE.
REQ-020 New request, wd_valid, and rd_ready outside their states SHALL be ignored without side effect.
REQ-021 rd_ready held high gives one read beat per 3 cycles; wd_valid held high gives one write beat per 4 cycles (5 with verify).

Reset
REQ-022 On rst_n low, immediately: state IDLE, req_ready=1 after release, wd_ready=0, rd_valid=0, rd_data=0, done=0, err=0, ram_en=0, ram_rw=0, ram_addr=0, ram_din=0.
REQ-023 Reset mid-burst SHALL abort the burst with no done pulse; RAM contents undefined only for the beat in ACCESS at reset.

Configuration
REQ-024 Macro RAM_CTRL_VERIFY_EN: when defined, each write beat inserts VERIFY after HOLD (en=1, rw=0), compares ram_dout to ram_din, sets err on mismatch.
REQ-025 Without RAM_CTRL_VERIFY_EN: no VERIFY state, err tied 0.

Structure
REQ-026 Shared package ram_ctrl_pkg: state enum, ADDR_W=8, DATA_W=8, LEN_W=2.
REQ-027 Single flat module; no sub-module.

Verification (bench model: 256x8 array written while ram_en && ram_rw)
REQ-028 Write addr 0x10 len 0 data 0xA5, then read 0x10 -> rd_data 0xA5, done pulses twice total.
REQ-029 Write burst addr 0xFE len 3 data 1,2,3,4 -> model[0xFE]=1, [0xFF]=2, [0x00]=3, [0x01]=4; read back identical.
REQ-030 Read burst len 3 with rd_ready low 5 cycles per beat -> rd_data stable, no beat lost, ram_en low during stalls.
REQ-031 Assert rst_n low during second ACCESS of a 4-beat write -> all outputs at reset values same cycle, no done, next request accepted.
REQ-032 With RAM_CTRL_VERIFY_EN, model forces bit0 stuck-at-0 at 0x20; write 0x21 to 0x20 -> err=1 after VERIFY; next accepted request clears err.
REQ-033 Check ram_addr/ram_din never change while ram_en=1 across all scenarios.
